// File: rtl/fm_fetch_unit.sv
// Operand-fetch stage: takes one search tuple, reads read/D, then C and both Occ lanes, and holds the bundle for compute.
// Optional one-entry read/D cache is enabled by defining FM_FETCH_CACHE_EN.
module fm_fetch_unit #(
  parameter int IDX_W   = 8,
  parameter int ADDR_W  = 12,
  parameter int POS_W   = 4,
  parameter int SYM_W   = 2,
  parameter int D_W     = 8,
  parameter int C_W     = 32,
  parameter int OCC_W   = 32,
  parameter int ROM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IDX_W-1:0]            i_in,
  input  logic [IDX_W-1:0]            z_in,
  input  logic [IDX_W-1:0]            k_in,
  input  logic [IDX_W-1:0]            l_in,
  input  logic [ADDR_W-1:0]           addr_in,
  input  logic [POS_W-1:0]            position_in,
  output logic                        ce_rom_read_and_D,
  output logic [IDX_W-1:0]            addr_rom_read_and_D,
  input  logic [D_W-1:0]              d_i,
  input  logic [SYM_W-1:0]            read_i,
  output logic                        ce_rom_C,
  output logic [SYM_W-1:0]            addr_rom_C,
  input  logic [C_W-1:0]              data_C,
  output logic                        ce_rom_Occ,
  output logic [IDX_W-1:0]            addr1_rom_Occ,
  output logic [IDX_W-1:0]            addr2_rom_Occ,
  input  logic [OCC_W-1:0]            data_occ1,
  input  logic [OCC_W-1:0]            data_occ2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            i_out,
  output logic [IDX_W-1:0]            z_out,
  output logic [IDX_W-1:0]            k_out,
  output logic [IDX_W-1:0]            l_out,
  output logic [ADDR_W-1:0]           addr_out,
  output logic [POS_W-1:0]            position_out,
  output logic [D_W-1:0]              d_i_out,
  output logic [SYM_W-1:0]            read_i_out,
  output logic [C_W-1:0]              C_out,
  output logic [(OCC_W>>SYM_W)-1:0]   occ_k_out,
  output logic [(OCC_W>>SYM_W)-1:0]   occ_l_out,
  output logic [1:0]                  state_dbg
);

  localparam int LANE_W = OCC_W >> SYM_W;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, RD_D, RD_OCC, OUT} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              accept, cache_hit, lat_done, start_occ;
  logic [SYM_W-1:0]  occ_sym;
  logic [IDX_W-1:0]  occ_k, occ_l;
  logic [D_W-1:0]    cache_d;
  logic [SYM_W-1:0]  cache_read;

  // Handshake: a transfer happens on a rising edge where valid && ready; the producer
  // holds valid and its data until then, and ready never depends on valid.
  assign accept    = in_valid && in_ready;
  assign lat_done  = (cnt == CNT_W'(ROM_LAT));
  assign start_occ = (accept && cache_hit) || (state == RD_D && lat_done);
  assign occ_sym   = (state == IDLE) ? cache_read : read_i;
  assign occ_k     = (state == IDLE) ? k_in : k_out;
  assign occ_l     = (state == IDLE) ? l_in : l_out;
  assign state_dbg = state;

`ifdef FM_FETCH_CACHE_EN
  logic              cache_valid;
  logic [IDX_W-1:0]  cache_i;

  assign cache_hit = cache_valid && (i_in == cache_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_i     <= '0;
      cache_d     <= '0;
      cache_read  <= '0;
    end else if (state == RD_D && lat_done) begin
      cache_valid <= 1'b1;
      cache_i     <= i_out;
      cache_d     <= d_i;
      cache_read  <= read_i;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_d    = '0;
  assign cache_read = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = cache_hit ? RD_OCC : RD_D;
      end
      RD_D:   if (lat_done) state_nx = RD_OCC;
      RD_OCC: if (lat_done) state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt                 <= '0;
      ce_rom_read_and_D   <= 1'b0;
      addr_rom_read_and_D <= '0;
      ce_rom_C            <= 1'b0;
      addr_rom_C          <= '0;
      ce_rom_Occ          <= 1'b0;
      addr1_rom_Occ       <= '0;
      addr2_rom_Occ       <= '0;
      i_out               <= '0;
      z_out               <= '0;
      k_out               <= '0;
      l_out               <= '0;
      addr_out            <= '0;
      position_out        <= '0;
      d_i_out             <= '0;
      read_i_out          <= '0;
      C_out               <= '0;
      occ_k_out           <= '0;
      occ_l_out           <= '0;
    end else begin
      ce_rom_read_and_D <= 1'b0;
      ce_rom_C          <= 1'b0;
      ce_rom_Occ        <= 1'b0;
      // Counter restarts on every state change so each ROM phase counts from its ce cycle.
      if (state_nx != state) cnt <= '0;
      else if (!lat_done)    cnt <= cnt + CNT_W'(1);

      if (accept) begin
        i_out        <= i_in;
        z_out        <= z_in;
        k_out        <= k_in;
        l_out        <= l_in;
        addr_out     <= addr_in;
        position_out <= position_in;
        if (cache_hit) begin
          d_i_out    <= cache_d;
          read_i_out <= cache_read;
        end else begin
          ce_rom_read_and_D   <= 1'b1;
          addr_rom_read_and_D <= i_in;
        end
      end

      if (state == RD_D && lat_done) begin
        d_i_out    <= d_i;
        read_i_out <= read_i;
      end

      if (start_occ) begin
        ce_rom_C      <= 1'b1;
        ce_rom_Occ    <= 1'b1;
        addr_rom_C    <= occ_sym;
        addr1_rom_Occ <= (occ_k == '0) ? '0 : occ_k - IDX_W'(1);
        addr2_rom_Occ <= occ_l;
      end

      // Occ(sym, k-1) is defined as 0 at the k==0 boundary, regardless of the ROM word.
      if (state == RD_OCC && lat_done) begin
        C_out     <= data_C;
        occ_l_out <= data_occ2[int'(read_i_out)*LANE_W +: LANE_W];
        occ_k_out <= (k_out == '0) ? '0 : data_occ1[int'(read_i_out)*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_fm_fetch_unit.sv
// Bench for fm_fetch_unit: two instances (ROM_LAT 1 and 3) with behavioural ROMs, timing checks
// and an expected-output queue.
module tb_fm_fetch_unit;

  localparam int IDX_W = 8, ADDR_W = 12, POS_W = 4, SYM_W = 2, D_W = 8, C_W = 32, OCC_W = 32;
  localparam int LANE_W = 8;
  localparam int EXP_W  = 4*IDX_W + ADDR_W + POS_W + D_W + SYM_W + C_W + 2*LANE_W;
`ifdef FM_FETCH_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst [2];
  logic              in_valid [2], in_ready [2], out_valid [2], out_ready [2];
  logic [IDX_W-1:0]  i_in [2], z_in [2], k_in [2], l_in [2];
  logic [ADDR_W-1:0] addr_in [2];
  logic [POS_W-1:0]  pos_in [2];
  logic              ce_rd [2], ce_c [2], ce_o [2];
  logic [IDX_W-1:0]  addr_rd [2], addr1 [2], addr2 [2];
  logic [SYM_W-1:0]  addr_c [2];
  logic [D_W-1:0]    d_s [2];
  logic [SYM_W-1:0]  read_s [2];
  logic [C_W-1:0]    data_c [2];
  logic [OCC_W-1:0]  occ1 [2], occ2 [2];
  logic [IDX_W-1:0]  i_out [2], z_out [2], k_out [2], l_out [2];
  logic [ADDR_W-1:0] addr_out [2];
  logic [POS_W-1:0]  pos_out [2];
  logic [D_W-1:0]    d_out [2];
  logic [SYM_W-1:0]  read_out [2];
  logic [C_W-1:0]    c_out [2];
  logic [LANE_W-1:0] occk_out [2], occl_out [2];
  logic [1:0]        state_dbg [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit               cache_v [2];
  logic [IDX_W-1:0] cache_i [2];

  // ROM contents
  function automatic logic [SYM_W-1:0] rd_sym(input logic [IDX_W-1:0] a);
    return SYM_W'(a + 8'd1);
  endfunction
  function automatic logic [D_W-1:0] d_val(input logic [IDX_W-1:0] a);
    return D_W'(a - 8'd2);
  endfunction
  function automatic logic [C_W-1:0] c_val(input logic [SYM_W-1:0] s);
    return 32'hC000_0005 | (32'(s) << 8);
  endfunction
  function automatic logic [LANE_W-1:0] exp_lane(input logic [IDX_W-1:0] a, input logic [SYM_W-1:0] s);
    return {a[5:0], s};
  endfunction
  function automatic logic [OCC_W-1:0] occ_word(input logic [IDX_W-1:0] a);
    logic [OCC_W-1:0] w;
    for (int j = 0; j < 4; j++) w[j*LANE_W +: LANE_W] = {a[5:0], 2'(j)};
    return w;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_u
    localparam int L = (g == 0) ? 1 : 3;
    logic             pv_d [4] = '{default: 1'b0};
    logic             pv_c [4] = '{default: 1'b0};
    logic             pv_o [4] = '{default: 1'b0};
    logic [IDX_W-1:0] pa_d [4], pa_1 [4], pa_2 [4];
    logic [SYM_W-1:0] pa_c [4];

    fm_fetch_unit #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .POS_W(POS_W), .SYM_W(SYM_W), .D_W(D_W),
                    .C_W(C_W), .OCC_W(OCC_W), .ROM_LAT(L)) dut (
      .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .i_in(i_in[g]), .z_in(z_in[g]), .k_in(k_in[g]), .l_in(l_in[g]),
      .addr_in(addr_in[g]), .position_in(pos_in[g]),
      .ce_rom_read_and_D(ce_rd[g]), .addr_rom_read_and_D(addr_rd[g]),
      .d_i(d_s[g]), .read_i(read_s[g]),
      .ce_rom_C(ce_c[g]), .addr_rom_C(addr_c[g]), .data_C(data_c[g]),
      .ce_rom_Occ(ce_o[g]), .addr1_rom_Occ(addr1[g]), .addr2_rom_Occ(addr2[g]),
      .data_occ1(occ1[g]), .data_occ2(occ2[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .i_out(i_out[g]), .z_out(z_out[g]), .k_out(k_out[g]), .l_out(l_out[g]),
      .addr_out(addr_out[g]), .position_out(pos_out[g]),
      .d_i_out(d_out[g]), .read_i_out(read_out[g]), .C_out(c_out[g]),
      .occ_k_out(occk_out[g]), .occ_l_out(occl_out[g]), .state_dbg(state_dbg[g])
    );

    // Data is valid only in cycle (ce cycle)+L; any other cycle shows garbage.
    always @(posedge clk) begin
      for (int j = 3; j > 0; j--) begin
        pv_d[j] <= pv_d[j-1]; pa_d[j] <= pa_d[j-1];
        pv_c[j] <= pv_c[j-1]; pa_c[j] <= pa_c[j-1];
        pv_o[j] <= pv_o[j-1]; pa_1[j] <= pa_1[j-1]; pa_2[j] <= pa_2[j-1];
      end
      pv_d[0] <= ce_rd[g]; pa_d[0] <= addr_rd[g];
      pv_c[0] <= ce_c[g];  pa_c[0] <= addr_c[g];
      pv_o[0] <= ce_o[g];  pa_1[0] <= addr1[g]; pa_2[0] <= addr2[g];
    end

    assign d_s[g]    = pv_d[L-1] ? d_val(pa_d[L-1])    : 8'hEE;
    assign read_s[g] = pv_d[L-1] ? rd_sym(pa_d[L-1])   : 2'd1;
    assign data_c[g] = pv_c[L-1] ? c_val(pa_c[L-1])    : 32'hDEAD_BEEF;
    assign occ1[g]   = pv_o[L-1] ? occ_word(pa_1[L-1]) : 32'hBAD0_BAD0;
    assign occ2[g]   = pv_o[L-1] ? occ_word(pa_2[L-1]) : 32'hBAD0_BAD0;
  end

  // scoreboard helpers
  task automatic check(input string tag, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] get_out(input int u);
    return {i_out[u], z_out[u], k_out[u], l_out[u], addr_out[u], pos_out[u],
            d_out[u], read_out[u], c_out[u], occk_out[u], occl_out[u]};
  endfunction

  function automatic logic [EXP_W-1:0] model(input logic [IDX_W-1:0] i, z, k, l,
                                             input logic [ADDR_W-1:0] a, input logic [POS_W-1:0] p);
    logic [SYM_W-1:0] s;
    s = rd_sym(i);
    return {i, z, k, l, a, p, d_val(i), s, c_val(s),
            (k == 0) ? 8'h00 : exp_lane(k - 8'd1, s), exp_lane(l, s)};
  endfunction

  // drivers
  task automatic drive(input int u, input logic [IDX_W-1:0] i, z, k, l,
                       input logic [ADDR_W-1:0] a, input logic [POS_W-1:0] p);
    in_valid[u] = 1'b1;
    i_in[u] = i; z_in[u] = z; k_in[u] = k; l_in[u] = l; addr_in[u] = a; pos_in[u] = p;
  endtask

  task automatic run_tuple(input int u, input logic [IDX_W-1:0] i, z, k, l,
                           input logic [ADDR_W-1:0] a, input logic [POS_W-1:0] p, input int stall);
    int L, exp_lat, exp_cc, c, cc_cycle, rd_cnt;
    bit hit, got, occ_ok, ready_low, stable;
    logic [IDX_W-1:0] rd_addr, a1, a2;
    logic [SYM_W-1:0] ac;
    logic [EXP_W-1:0] e;
    L = (u == 0) ? 1 : 3;
    hit = CACHE_ON && cache_v[u] && (cache_i[u] == i);
    if (!hit) begin cache_v[u] = 1'b1; cache_i[u] = i; end
    exp_lat = hit ? 2 + L : 3 + 2*L;
    exp_cc  = hit ? 1 : 2 + L;
    rd_addr = '0; a1 = '0; a2 = '0; ac = '0;
    @(negedge clk);
    check($sformatf("u%0d_in_ready_idle", u), in_ready[u], 1);
    drive(u, i, z, k, l, a, p);
    exp_q.push_back(model(i, z, k, l, a, p));
    @(posedge clk);
    c = 0; got = 0; rd_cnt = 0; cc_cycle = -1; occ_ok = 1; ready_low = 1;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      in_valid[u] = 1'b0;
      if (ce_rd[u]) begin rd_cnt++; rd_addr = addr_rd[u]; end
      if (ce_c[u]) begin
        cc_cycle = c; ac = addr_c[u]; a1 = addr1[u]; a2 = addr2[u];
        if (!ce_o[u]) occ_ok = 0;
      end
      if (in_ready[u]) ready_low = 0;
      got = out_valid[u];
    end
    check($sformatf("u%0d_out_valid_cycle", u), c, exp_lat);
    check($sformatf("u%0d_c_ce_cycle", u), cc_cycle, exp_cc);
    check($sformatf("u%0d_rd_ce_count", u), rd_cnt, hit ? 0 : 1);
    if (!hit) check($sformatf("u%0d_rd_addr", u), rd_addr, i);
    check($sformatf("u%0d_addr_c", u), ac, rd_sym(i));
    check($sformatf("u%0d_addr1_occ", u), a1, (k == 0) ? 8'h00 : k - 8'd1);
    check($sformatf("u%0d_addr2_occ", u), a2, l);
    check($sformatf("u%0d_occ_ce_with_c", u), occ_ok, 1);
    check($sformatf("u%0d_in_ready_busy", u), ready_low, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    stable = 1;
    for (int s = 0; s < stall; s++) begin
      if (get_out(u) !== e || !out_valid[u] || in_ready[u]) stable = 0;
      @(negedge clk);
    end
    if (stall > 0) check($sformatf("u%0d_stall_stable", u), stable, 1);
    out_ready[u] = 1'b1;
    check($sformatf("u%0d_out_data", u), get_out(u), e);
    @(posedge clk);
    @(negedge clk);
    out_ready[u] = 1'b0;
    check($sformatf("u%0d_out_valid_after_hs", u), out_valid[u], 0);
    check($sformatf("u%0d_in_ready_after_hs", u), in_ready[u], 1);
  endtask

  task automatic check_reset_state(input int u);
    check($sformatf("u%0d_rst_out_fields", u), get_out(u), '0);
    check($sformatf("u%0d_rst_rom_ports", u),
          {ce_rd[u], addr_rd[u], ce_c[u], addr_c[u], ce_o[u], addr1[u], addr2[u], out_valid[u]}, '0);
    check($sformatf("u%0d_rst_in_ready", u), in_ready[u], 1);
  endtask

  task automatic abort_tuple(input int u, input logic [IDX_W-1:0] i, k, l);
    int c;
    bit seen;
    @(negedge clk);
    drive(u, i, 8'h11, k, l, 12'h777, 4'h7);
    @(posedge clk);
    c = 0; seen = 0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      in_valid[u] = 1'b0;
      seen = ce_c[u];
    end
    check($sformatf("u%0d_abort_reached_occ", u), seen, 1);
    rst[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state(u);
    rst[u] = 1'b0;
    cache_v[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; in_valid[u] = 1'b0; out_ready[u] = 1'b0;
      i_in[u] = '0; z_in[u] = '0; k_in[u] = '0; l_in[u] = '0; addr_in[u] = '0; pos_in[u] = '0;
      cache_v[u] = 1'b0; cache_i[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) check_reset_state(u);
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int u = 0; u < 2; u++) begin
      run_tuple(u, 8'd5, 8'd1, 8'd4, 8'd9, 12'h123, 4'd3, 0);
      run_tuple(u, 8'd5, 8'd2, 8'd0, 8'd7, 12'hABC, 4'd15, 10);
      for (int n = 0; n < 4; n++) begin
        logic [IDX_W-1:0] ri, rk;
        ri = ($urandom_range(0, 2) == 0) ? cache_i[u] : 8'($urandom_range(0, 255));
        rk = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        run_tuple(u, ri, 8'($urandom_range(0, 255)), rk, 8'($urandom_range(0, 255)),
                  12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
      abort_tuple(u, 8'd9, 8'd3, 8'd20);
      run_tuple(u, 8'd5, 8'd3, 8'd255, 8'd0, 12'hFFF, 4'd0, 1);
      run_tuple(u, 8'd5, 8'd4, 8'd1, 8'd255, 12'h001, 4'd8, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_fetch_unit.md
# fm_fetch_unit

Parametrised operand-fetch stage of the backtracking search pipeline: accepts one search tuple (i, z, k, l, addr, position) from the parameter stage over a valid/ready handshake, performs the dependent ROM lookups (read/D first, then C and both Occ counts selected by the fetched read symbol), and presents the bundled operands to the compute stage. Supersedes the fixed-width fetch block: widths and ROM latency are parameters, Occ lane selection and the k==0 boundary are handled internally, and back-pressure is supported.

## Interface
- IDX_W, 8, width of i/z/k/l and of the read/D and Occ ROM addresses
- ADDR_W, 12, width of the tuple tag addr
- POS_W, 4, width of position
- SYM_W, 2, read-symbol width; C ROM address width; Occ lanes = 2^SYM_W
- D_W, 8, width of D entries
- C_W, 32, width of C ROM word
- OCC_W, 32, Occ ROM word width, packed 2^SYM_W lanes of OCC_W>>SYM_W bits, lane 0 in LSBs
- ROM_LAT, 1, ROM read latency in cycles (legal 1..4), common to all ROMs
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid / in_ready  in / out  1  input tuple handshake
- i_in, z_in, k_in, l_in  in  IDX_W  search parameters
- addr_in  in  ADDR_W  tuple tag;  position_in  in  POS_W  execution position
- ce_rom_read_and_D  out  1;  addr_rom_read_and_D  out  IDX_W
- d_i  in  D_W;  read_i  in  SYM_W  read/D ROM data
- ce_rom_C  out  1;  addr_rom_C  out  SYM_W;  data_C  in  C_W
- ce_rom_Occ  out  1;  addr1_rom_Occ, addr2_rom_Occ  out  IDX_W;  data_occ1, data_occ2  in  OCC_W
- out_valid / out_ready  out / in  1  output handshake
- i_out, z_out, k_out, l_out  out  IDX_W;  addr_out  ADDR_W;  position_out  POS_W
- d_i_out  out  D_W;  read_i_out  out  SYM_W;  C_out  out  C_W
- occ_k_out, occ_l_out  out  OCC_W>>SYM_W  Occ(read_i, k-1), Occ(read_i, l)

## Operation
- FSM: IDLE -> RD_D -> RD_OCC -> OUT -> IDLE.
- IDLE: in_ready=1; on in_valid capture all tuple fields, go RD_D.
- RD_D: ce_rom_read_and_D=1 for first cycle only, addr=i; wait counter 1..ROM_LAT; capture d_i/read_i at ROM_LAT; go RD_OCC.
- RD_OCC: first cycle ce_rom_C=ce_rom_Occ=1, addr_rom_C=read_i, addr1=k-1 (0 when k==0), addr2=l; capture at ROM_LAT: C_out=data_C, occ_l_out=lane read_i of data_occ2, occ_k_out=lane read_i of data_occ1, forced 0 when k==0; go OUT.
- OUT: out_valid=1, outputs stable until out_ready; then IDLE.
- ce outputs are single-cycle pulses; addresses hold last value otherwise.
- No arithmetic beyond k-1 (IDX_W, only when k!=0); l<k passed through unchecked.
- Reset: all outputs 0, state IDLE; reset mid-transaction abandons it, late ROM data ignored.

## Timing
- Accept handshake in cycle T; read/D ce in T+1; ROM data valid during cycle (ce cycle)+ROM_LAT.
- C/Occ ce in T+2+ROM_LAT; out_valid first high in T+3+2*ROM_LAT (ROM_LAT=1: T+5).
- Cache hit (see Configuration): C/Occ ce in T+1; out_valid in T+2+ROM_LAT.
- in_ready low from T+1 until the cycle after the out handshake; one tuple in flight.
- out_valid may stall indefinitely; no output field changes while out_valid && !out_ready.

## Configuration
- FM_FETCH_CACHE_EN defined: one-entry cache of last (i, d_i, read_i), valid bit cleared by rst; accept with i_in equal to cached i skips RD_D (no read/D ce), uses cached d_i/read_i.
- Undefined: every tuple performs RD_D; no cache registers.

## Test plan
- ROM_LAT=1, i=5 (read=2, D=3), k=4, l=9: C ce in T+3, out_valid in T+5, read_i_out=2, occ_k_out=lane2 @addr3, occ_l_out=lane2 @addr9.
- k=0, l=7: addr1=0, occ_k_out=0, occ_l_out=lane read_i @addr7.
- out_ready held low 10 cycles: outputs constant, in_ready=0, then IDLE one cycle after handshake.
- ROM_LAT=3: out_valid exactly T+9; data presented off-cycle ignored.
- rst asserted during RD_OCC: next cycle all outputs 0, in_ready=1; new tuple completes correctly.
- FM_FETCH_CACHE_EN, two tuples i=5: second has no read/D ce, out_valid at T+2+ROM_LAT, same read_i_out.
